config_chain_loader: RTL and testbench
======================================

CONFIG_CHAIN_LOADER -- requirements
Module: config_chain_loader

Interface
REQ-001 The block SHALL have parameter WORD_W, default 8, input word width in bits (1..32).
REQ-002 The block SHALL have parameter CHAIN_LEN, default 64, number of flops in the configuration chain (>=1).
REQ-003 The block SHALL have port C  input  1  clock; all state updates on posedge C.
REQ-004 The block SHALL have port RN  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port start  input  1  request to program the chain.
REQ-006 The block SHALL have port din  input  WORD_W  bitstream word, LSB shifted first.
REQ-007 The block SHALL have port din_valid  input  1  din holds a valid word.
REQ-008 The block SHALL have port din_ready  output  1  the block accepts din this cycle.
REQ-009 The block SHALL have port cfg_head  output  1  serial data to the first chain flop D input.
REQ-010 The block SHALL have port cfg_en  output  1  chain shift enable; the chain captures cfg_head on the posedge C where cfg_en=1.
REQ-011 The block SHALL have port busy  output  1  high in FETCH or SHIFT.
REQ-012 The block SHALL have port done  output  1  high while in DONE.
REQ-013 The block SHALL have port bit_cnt  output  clog2(CHAIN_LEN+1)  bits shifted since the last start.

Function
REQ-014 The block SHALL implement states IDLE, FETCH, SHIFT, DONE.
REQ-015 In IDLE the block SHALL go to FETCH on start=1 and clear bit_cnt; outputs: din_ready=0, cfg_en=0.
REQ-016 In FETCH the block SHALL drive din_ready=1 and cfg_en=0; on din_valid=1 it SHALL load din into the shift register, set word-bit counter to WORD_W, and go to SHIFT next cycle.
REQ-017 In SHIFT the block SHALL drive cfg_en=1, cfg_head=shift register bit 0, and din_ready=0 every cycle; at each posedge C it SHALL shift right, increment bit_cnt, and decrement the word-bit counter.
REQ-018 When bit_cnt reaches CHAIN_LEN in SHIFT, the block SHALL go to DONE even if word bits remain; the remaining bits are discarded.
REQ-019 Otherwise, when the word-bit counter reaches 0, the block SHALL return to FETCH, leaving one cycle with cfg_en=0 per word.
REQ-020 cfg_en and cfg_head SHALL depend only on registered state, with no combinational path from any input.
REQ-021 In DONE the block SHALL drive done=1 and cfg_en=0; start=1 SHALL go to FETCH and clear bit_cnt.
REQ-022 start SHALL be ignored in FETCH and SHIFT.
REQ-023 din_valid=0 in FETCH SHALL hold FETCH indefinitely with cfg_en=0 and no change in chain state.
REQ-024 A word accepted at edge N SHALL produce the first cfg_en=1 in the cycle after edge N.
REQ-025 bit_cnt SHALL never exceed CHAIN_LEN.

Reset
REQ-026 RN=0 SHALL asynchronously force IDLE, bit_cnt=0, shift register=0, word-bit counter=0, and outputs din_ready=0, cfg_en=0, cfg_head=0, busy=0, done=0.
REQ-027 RN=0 during SHIFT SHALL abort mid-word; the chain is left partially loaded and a new start is required.
REQ-028 Release of RN SHALL take effect on the next posedge C.

Structure
REQ-029 A shared package SHALL hold the state enum and the bit_cnt width function clog2(CHAIN_LEN+1).
REQ-030 The parallel-in serial-out word register with its word-bit counter SHALL be a sub-module cfg_piso; the FSM and bit_cnt SHALL stay in config_chain_loader.

Verification
REQ-031 With CHAIN_LEN=16, WORD_W=8, start then words 0xA5 and 0x3C with din_valid always 1 -> cfg_head sequence 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0 across 16 cfg_en cycles; done=1 at cycle 19 after start; bit_cnt=16.
REQ-032 With CHAIN_LEN=12, WORD_W=8, words 0xFF and 0x0F -> exactly 12 cfg_en pulses, 8 ones then 4 ones, then DONE; the upper 4 bits of word 2 are never shifted.
REQ-033 With din_valid=0 for 5 cycles in FETCH -> cfg_en stays 0 and bit_cnt is unchanged for those cycles; loading resumes correctly afterwards.
REQ-034 With RN pulsed low at the 3rd SHIFT cycle -> all outputs 0 immediately; a subsequent start reloads from bit_cnt=0.
REQ-035 With start=1 held through FETCH and SHIFT -> no restart until DONE; start in DONE restarts and done drops the next cycle.
REQ-036 With a 16-flop dffr chain model driven by cfg_head/cfg_en -> the chain contents equal the expected bitstream after done.

Source files
------------

// File: rtl/config_chain_loader_pkg.sv
// Shared types and sizing helpers for the configuration chain loader.
// Holds the loader state enum and the counter-width function.
package config_chain_loader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // Bits needed to hold the values 0..max_val, i.e. clog2(max_val+1).
   function automatic int cnt_w(input int max_val);
      if (max_val < 1) begin
         return 1;
      end else begin
         return $clog2(max_val + 1);
      end
   endfunction

endpackage

// File: rtl/config_chain_loader_piso.sv
// Parallel-in serial-out word register for the chain loader.
// Emits the loaded word LSB first and counts the bits still pending.
module cfg_piso
   import config_chain_loader_pkg::*;
#(
   parameter int WORD_W = 8
) (
   input  logic              C,
   input  logic              RN,
   input  logic              load,
   input  logic              shift,
   input  logic [WORD_W-1:0] din,
   output logic              head,
   output logic              last
);

   localparam int WCW = cnt_w(WORD_W);

   logic [WORD_W-1:0] sr_q, sr_d;
   logic [WCW-1:0]    wcnt_q, wcnt_d;

   // Load or shift the word register and its pending-bit count.
   always_comb begin
      sr_d   = sr_q;
      wcnt_d = wcnt_q;
      if (load) begin
         sr_d   = din;
         wcnt_d = WCW'(WORD_W);
      end else if (shift) begin
         sr_d   = sr_q >> 1'b1;
         wcnt_d = wcnt_q - WCW'(1);
      end else begin
         sr_d   = sr_q;
         wcnt_d = wcnt_q;
      end
   end

   // Word register and pending-bit count flops.
   always_ff @(posedge C or negedge RN) begin
      if (!RN) begin
         sr_q   <= {WORD_W{1'b0}};
         wcnt_q <= {WCW{1'b0}};
      end else begin
         sr_q   <= sr_d;
         wcnt_q <= wcnt_d;
      end
   end

   assign head = sr_q[0];
   assign last = (wcnt_q == WCW'(1));

endmodule

// File: rtl/config_chain_loader.sv
// Streams words into a serial configuration chain, LSB first.
// Stops after exactly CHAIN_LEN shifted bits, discarding any surplus word bits.
module config_chain_loader
   import config_chain_loader_pkg::*;
#(
   parameter int WORD_W    = 8,
   parameter int CHAIN_LEN = 64
) (
   input  logic                           C,
   input  logic                           RN,
   input  logic                           start,
   input  logic [WORD_W-1:0]              din,
   input  logic                           din_valid,
   output logic                           din_ready,
   output logic                           cfg_head,
   output logic                           cfg_en,
   output logic                           busy,
   output logic                           done,
   output logic [cnt_w(CHAIN_LEN)-1:0]    bit_cnt
);

   localparam int             BCW      = cnt_w(CHAIN_LEN);
   localparam logic [BCW-1:0] LAST_CNT = BCW'(CHAIN_LEN - 1);

   state_e         state_q, state_d;
   logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
   logic           load_s, shift_s, piso_head_s, piso_last_s;

   cfg_piso #(.WORD_W(WORD_W)) u_piso (
      .C     (C),
      .RN    (RN),
      .load  (load_s),
      .shift (shift_s),
      .din   (din),
      .head  (piso_head_s),
      .last  (piso_last_s)
   );

   // State and shifted-bit counter flops.
   always_ff @(posedge C or negedge RN) begin
      if (!RN) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= {BCW{1'b0}};
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end

   // Next state; the chain-length limit wins over the word boundary.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d   = ST_FETCH;
               bit_cnt_d = {BCW{1'b0}};
            end else begin
               state_d   = state_q;
            end
         end
         ST_FETCH: begin
            if (din_valid) begin
               state_d = ST_SHIFT;
            end else begin
               state_d = ST_FETCH;
            end
         end
         ST_SHIFT: begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
            if (bit_cnt_q == LAST_CNT) begin
               state_d = ST_DONE;
            end else if (piso_last_s) begin
               state_d = ST_FETCH;
            end else begin
               state_d = ST_SHIFT;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            bit_cnt_d = {BCW{1'b0}};
         end
      endcase
   end

   // Outputs decoded from registered state only; load_s feeds the word register.
   always_comb begin
      din_ready = 1'b0;
      cfg_en    = 1'b0;
      cfg_head  = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      load_s    = 1'b0;
      shift_s   = 1'b0;
      case (state_q)
         ST_FETCH: begin
            din_ready = 1'b1;
            busy      = 1'b1;
            load_s    = din_valid;
         end
         ST_SHIFT: begin
            cfg_en    = 1'b1;
            cfg_head  = piso_head_s;
            busy      = 1'b1;
            shift_s   = 1'b1;
         end
         ST_DONE: begin
            done      = 1'b1;
         end
         default: begin
            din_ready = 1'b0;
         end
      endcase
   end

   assign bit_cnt = bit_cnt_q;

endmodule

// File: tb/tb_config_chain_loader.sv
// Directed bench for config_chain_loader with a bitstream-level reference model.
// Two instances: a 16-flop chain and a 12-flop chain, both with 8-bit words.
module tb_config_chain_loader;

   localparam int W   = 8;
   localparam int CL0 = 16;
   localparam int CL1 = 12;

   logic C = 1'b0;
   always #5 C = ~C;

   logic [1:0]   rn, start, din_valid, din_ready, cfg_head, cfg_en, busy, done;
   logic [W-1:0] din [2];
   logic [4:0]   bit_cnt0;
   logic [3:0]   bit_cnt1;

   int n_checks = 0;
   int n_fail   = 0;

   logic [W-1:0] words [4];
   int           exp_bits [2][64];
   int           exp_len  [2];
   int           plan_gen [2];

   config_chain_loader #(.WORD_W(W), .CHAIN_LEN(CL0)) dut16 (
      .C(C), .RN(rn[0]), .start(start[0]), .din(din[0]), .din_valid(din_valid[0]),
      .din_ready(din_ready[0]), .cfg_head(cfg_head[0]), .cfg_en(cfg_en[0]),
      .busy(busy[0]), .done(done[0]), .bit_cnt(bit_cnt0)
   );

   config_chain_loader #(.WORD_W(W), .CHAIN_LEN(CL1)) dut12 (
      .C(C), .RN(rn[1]), .start(start[1]), .din(din[1]), .din_valid(din_valid[1]),
      .din_ready(din_ready[1]), .cfg_head(cfg_head[1]), .cfg_en(cfg_en[1]),
      .busy(busy[1]), .done(done[1]), .bit_cnt(bit_cnt1)
   );

   function automatic int bcnt(input int d);
      return (d == 0) ? int'(bit_cnt0) : int'(bit_cnt1);
   endfunction

   task automatic check(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
      end
   endtask

   // Model: the chain must receive the words' bits LSB first, cut at the chain length.
   task automatic plan(input int d, input int nw);
      int len = 0;
      int cl  = (d == 0) ? CL0 : CL1;
      for (int i = 0; i < nw; i++) begin
         for (int b = 0; b < W; b++) begin
            if (len < cl) begin
               exp_bits[d][len] = int'(words[i][b]);
               len++;
            end
         end
      end
      exp_len[d] = len;
      plan_gen[d]++;
   endtask

   // After N shifts the first bit sits in flop N-1, the last bit in flop 0.
   function automatic int exp_chain(input int d);
      logic [15:0] v = 16'h0000;
      for (int k = 0; k < exp_len[d]; k++) v[exp_len[d]-1-k] = (exp_bits[d][k] != 0);
      return int'(v);
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_mon
      int          idx      = 0;
      int          seen_gen = 0;
      logic [15:0] chain    = 16'h0000;

      always @(negedge C) begin
         int cur;
         cur = (seen_gen == plan_gen[g]) ? idx : 0;
         seen_gen <= plan_gen[g];
         if (rn[g] && cfg_en[g]) begin
            if (cur < exp_len[g]) begin
               check($sformatf("cfg_head%0d[%0d]", g, cur), int'(cfg_head[g]), exp_bits[g][cur]);
            end else begin
               n_checks++;
               n_fail++;
               $display("FAIL extra_cfg_en%0d: got pulse %0d, expected at most %0d", g, cur + 1, exp_len[g]);
            end
            check($sformatf("bit_cnt%0d_at_shift", g), bcnt(g), cur);
            idx <= cur + 1;
         end else begin
            idx <= cur;
         end
      end

      always @(posedge C) begin
         if (cfg_en[g]) chain <= {chain[14:0], cfg_head[g]};
      end
   end

   task automatic run_load(input int d, input int nw, input int stall_after, input int stall_len,
                           input bit hold_start, output int cyc);
      int wi    = 0;
      int stall = 0;
      bit acc   = 1'b0;
      bit fin   = 1'b0;
      plan(d, nw);
      start[d]     = 1'b1;
      din_valid[d] = 1'b0;
      cyc = 0;
      while (!fin && cyc < 100) begin
         @(negedge C);
         cyc++;
         if (acc) wi++;
         if (!hold_start) start[d] = 1'b0;
         if (done[d] === 1'b1) begin
            fin = 1'b1;
         end else if (wi == stall_after && din_ready[d] && stall < stall_len) begin
            din_valid[d] = 1'b0;
            stall++;
            check("stall_cfg_en", int'(cfg_en[d]), 0);
            check("stall_bit_cnt", bcnt(d), W * stall_after);
         end else begin
            din_valid[d] = (wi < nw);
            din[d]       = (wi < nw) ? words[wi] : {W{1'b0}};
         end
         acc = din_ready[d] && din_valid[d];
      end
      if (!fin) begin
         n_checks++;
         n_fail++;
         $display("FAIL done_timeout%0d: got no done after %0d cycles, expected done", d, cyc);
      end
   endtask

   initial begin
      int          cyc;
      int          n_sh;
      logic [15:0] pat;
      rn = 2'b00; start = 2'b00; din_valid = 2'b00;
      din[0] = 8'h00; din[1] = 8'h00;
      plan_gen[0] = 0; plan_gen[1] = 0;
      exp_len[0] = 0;  exp_len[1] = 0;

      repeat (2) @(negedge C);
      for (int d = 0; d < 2; d++) begin
         check("rst_busy", int'(busy[d]), 0);
         check("rst_done", int'(done[d]), 0);
         check("rst_cfg_en", int'(cfg_en[d]), 0);
         check("rst_cfg_head", int'(cfg_head[d]), 0);
         check("rst_din_ready", int'(din_ready[d]), 0);
         check("rst_bit_cnt", bcnt(d), 0);
      end
      rn = 2'b11;
      @(negedge C);

      // 0xA5, 0x3C into the 16-flop chain
      words[0] = 8'hA5; words[1] = 8'h3C;
      run_load(0, 2, 99, 0, 1'b0, cyc);
      pat = 16'b1010_0101_0011_1100;
      for (int k = 0; k < 16; k++) check($sformatf("model_seq[%0d]", k), exp_bits[0][k], int'(pat[15-k]));
      check("done_cycle_a5_3c", cyc, 19);
      check("done_a5_3c", int'(done[0]), 1);
      check("bit_cnt_a5_3c", bcnt(0), 16);
      check("chain_a5_3c", int'(g_mon[0].chain), exp_chain(0));
      check("chain_a5_3c_lit", int'(g_mon[0].chain), 32'h0000A53C);

      // 0xFF, 0x0F into the 12-flop chain: upper nibble of word 2 dropped
      words[0] = 8'hFF; words[1] = 8'h0F;
      run_load(1, 2, 99, 0, 1'b0, cyc);
      check("model_len12", exp_len[1], 12);
      check("done_cycle_ff_0f", cyc, 15);
      check("bit_cnt_ff_0f", bcnt(1), 12);
      repeat (3) @(negedge C);
      check("pulses_ff_0f", g_mon[1].idx, 12);
      check("done_hold_ff_0f", int'(done[1]), 1);
      check("chain_ff_0f", int'(g_mon[1].chain[11:0]), exp_chain(1));
      check("chain_ff_0f_lit", int'(g_mon[1].chain[11:0]), 32'h00000FFF);

      // start held throughout, 5-cycle din_valid stall before the second word
      words[0] = 8'h5A; words[1] = 8'hC3;
      run_load(0, 2, 1, 5, 1'b1, cyc);
      check("done_cycle_stall", cyc, 24);
      check("bit_cnt_stall", bcnt(0), 16);
      check("chain_stall", int'(g_mon[0].chain), exp_chain(0));

      // start still high in DONE: restart, then abort with RN at the 3rd shift
      words[0] = 8'h96; words[1] = 8'h69;
      plan(0, 2);
      @(negedge C);
      check("restart_done", int'(done[0]), 0);
      check("restart_busy", int'(busy[0]), 1);
      check("restart_bit_cnt", bcnt(0), 0);
      start[0] = 1'b0;
      din[0] = words[0];
      din_valid[0] = 1'b1;
      n_sh = 0;
      for (int i = 0; i < 30 && n_sh < 3; i++) begin
         @(negedge C);
         if (cfg_en[0]) n_sh++;
      end
      check("abort_shift_cycles", n_sh, 3);
      rn[0] = 1'b0;
      #1;
      check("abort_cfg_en", int'(cfg_en[0]), 0);
      check("abort_cfg_head", int'(cfg_head[0]), 0);
      check("abort_busy", int'(busy[0]), 0);
      check("abort_done", int'(done[0]), 0);
      check("abort_din_ready", int'(din_ready[0]), 0);
      check("abort_bit_cnt", bcnt(0), 0);
      din_valid[0] = 1'b0;
      @(negedge C);
      rn[0] = 1'b1;
      @(negedge C);
      check("post_abort_idle", int'(busy[0]), 0);

      // fresh load after the abort starts from bit_cnt 0
      words[0] = 8'h0F; words[1] = 8'hF0;
      run_load(0, 2, 99, 0, 1'b0, cyc);
      check("done_cycle_reload", cyc, 19);
      check("bit_cnt_reload", bcnt(0), 16);
      check("chain_reload", int'(g_mon[0].chain), exp_chain(0));
      check("chain_reload_lit", int'(g_mon[0].chain), 32'h0000F00F);

      repeat (2) @(negedge C);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
